// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RV32I main controller.
//   - state_e     : controller state encodings (also exported on state_num)
//   - OPC_*       : RV32I major opcodes the controller recognises
//   - iclass_t    : one-hot instruction class produced by ctrl_opcode_decode
//   - M2R_/PCS_/SRCA_/SRCB_/ALU_* : datapath mux-select encodings
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADR   = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JAL       = 4'd9,
    ST_EXEC_I    = 4'd10,
    ST_JALR      = 4'd11,
    ST_LUI       = 4'd12,
    ST_TRAP      = 4'd13
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_OPIMM  = 7'd19;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_LUI    = 7'd55;

  // Writeback select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  // PC source
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JALR   = 2'b10;
  // ALU A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  // ALU B select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  // ALU operation
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASSB  = 2'b11;

  typedef struct packed {
    logic load;
    logic store;
    logic op;
    logic opimm;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
  } iclass_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// ctrl_opcode_decode: purely combinational opcode classifier.
// Ports:
//   opcode  in  [OPCODE_W-1:0] : opcode field from the IR
//   iclass  out iclass_t       : one-hot instruction class (all zero if illegal)
//   illegal out 1              : opcode is not one the controller executes
module ctrl_opcode_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             iclass,
  output logic                illegal
);

  always_comb begin
    iclass  = '0;
    illegal = 1'b0;
    case (opcode)
      OPCODE_W'(OPC_LOAD):   iclass.load   = 1'b1;
      OPCODE_W'(OPC_STORE):  iclass.store  = 1'b1;
      OPCODE_W'(OPC_OP):     iclass.op     = 1'b1;
      OPCODE_W'(OPC_OPIMM):  iclass.opimm  = 1'b1;
      OPCODE_W'(OPC_BRANCH): iclass.branch = 1'b1;
      OPCODE_W'(OPC_JAL):    iclass.jal    = 1'b1;
      OPCODE_W'(OPC_JALR):   iclass.jalr   = 1'b1;
      OPCODE_W'(OPC_LUI):    iclass.lui    = 1'b1;
      default:               illegal       = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_rv.sv
// multicycle_ctrl_rv: Moore main controller for the multicycle RV32I datapath.
// Optional build macro: CTRL_PERF_EN adds the instret/stall_cnt counters.
// Ports:
//   clk, reset (sync, active-high)
//   opcode     in  [OPCODE_W-1:0] : IR opcode field
//   mem_ready  in  1 : memory completes the current access this cycle
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write : enables
//   mem_to_reg, pc_source, alu_src_a, alu_src_b, alu_op [1:0] : mux selects
//   illegal    out 1 : controller is in the trap state
//   instret, stall_cnt out [CNT_W-1:0] : only with CTRL_PERF_EN
//   state_num  out [STATE_W-1:0] : current state, debug view
// Memory handshake: an access in FETCH/MEM_READ/MEM_WRITE is held (request
// and address select stable) until the cycle mem_ready=1, which completes it.
module multicycle_ctrl_rv
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 7,
  parameter int STATE_W       = 4,
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          pc_source,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal,
`ifdef CTRL_PERF_EN
  output logic [CNT_W-1:0]    instret,
  output logic [CNT_W-1:0]    stall_cnt,
`endif
  output logic [STATE_W-1:0]  state_num
);

  logic [3:0] state_q, state_d;
  logic       mem_rdy;
  iclass_t    iclass;
  logic       opc_illegal;

  // Without the handshake every memory access completes in its first cycle.
  assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  ctrl_opcode_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (opcode),
    .iclass  (iclass),
    .illegal (opc_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:     state_d = mem_rdy ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (opc_illegal)                    state_d = ST_TRAP;
        else if (iclass.load | iclass.store) state_d = ST_MEM_ADR;
        else if (iclass.op)                 state_d = ST_EXEC_R;
        else if (iclass.opimm)              state_d = ST_EXEC_I;
        else if (iclass.branch)             state_d = ST_BRANCH;
        else if (iclass.jal)                state_d = ST_JAL;
        else if (iclass.jalr)               state_d = ST_JALR;
        else                                state_d = ST_LUI;
      end
      ST_MEM_ADR:   state_d = iclass.load ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  state_d = mem_rdy ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: state_d = mem_rdy ? ST_FETCH : ST_MEM_WRITE;
      ST_EXEC_R,
      ST_EXEC_I,
      ST_LUI:       state_d = ST_ALU_WB;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_FETCH;  // includes all single-cycle tails
    endcase
  end

  // Moore output decode; reset overrides everything to zero.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = M2R_ALUOUT;
    pc_source     = PCS_ALU;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    illegal       = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_DECODE: begin
          // ALUOut <= OldPC + imm: the branch/JAL target
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_ADR: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_READ: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        ST_MEM_WRITE: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        ST_EXEC_R: begin
          alu_src_a = SRCA_REG;
          alu_op    = ALU_FUNCT;
        end
        ST_EXEC_I: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_FUNCT;
        end
        ST_LUI: begin
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_PASSB;
        end
        ST_ALU_WB: reg_write = 1'b1;
        ST_BRANCH: begin
          alu_src_a     = SRCA_REG;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
        end
        ST_JAL: begin
          pc_write   = 1'b1;
          pc_source  = PCS_ALUOUT;
          reg_write  = 1'b1;
          mem_to_reg = M2R_PC;
        end
        ST_JALR: begin
          // rd gets the pre-edge PC (PC+4) since PC and RF update together
          alu_src_a  = SRCA_REG;
          alu_src_b  = SRCB_IMM;
          pc_source  = PCS_JALR;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          mem_to_reg = M2R_PC;
        end
        ST_TRAP: illegal = 1'b1;
        default: begin
          // FETCH, and any undefined encoding, behave as FETCH
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_rdy;
          pc_write  = mem_rdy;
        end
      endcase
    end
  end

  assign state_num = reset ? '0 : STATE_W'(state_q);

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] instret_q, stall_q;
  logic             retire, stall;

  assign retire = (state_q != ST_FETCH) && (state_d == ST_FETCH);
  assign stall  = !mem_rdy && ((state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                               (state_q == ST_MEM_WRITE));

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire) instret_q <= instret_q + 1'b1;
      if (stall)  stall_q   <= stall_q + 1'b1;
    end
  end

  assign instret   = reset ? '0 : instret_q;
  assign stall_cnt = reset ? '0 : stall_q;
`endif

endmodule
